// File: rtl/target_port.sv
// Bit-serial request deserializer / read-data serializer in front of the target memory.
// Optional ack timeout in WAIT_ACK is enabled by defining TARGET_PORT_TIMEOUT_EN.
module target_port #(
    parameter int ADDR_BITS = 16,
    parameter int TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    input  logic        sin_valid,
    output logic        sout,
    output logic        sout_valid,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic        mem_addr_valid,
    output logic [7:0]  mem_wdata,
    output logic        mem_wdata_valid,
    output logic        mem_rw,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rdata_valid,
    input  logic        mem_ack,
    input  logic        mem_ready
);

`ifdef TARGET_PORT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_RX_ADDR, S_RX_DATA, S_ISSUE, S_WAIT_ACK, S_TX
    } state_t;

    state_t                 r_state, w_next;
    logic [4:0]             r_bit_cnt;
    logic                   r_rw;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [7:0]             r_wdata, r_rdata;
    logic [15:0]            r_tcnt;
    logic                   r_done, r_err;
    logic                   r_addr_vld, r_wdata_vld, r_mem_rw;
    logic [15:0]            r_mem_addr;
    logic [7:0]             r_mem_wdata;

    logic w_addr_last, w_byte_last, w_timeout;

    assign w_addr_last = (r_bit_cnt == 5'(ADDR_BITS - 1));
    assign w_byte_last = (r_bit_cnt == 5'd7);
    // ack in the expiry cycle takes priority over the timeout
    assign w_timeout   = TO_EN && (r_state == S_WAIT_ACK) && !mem_ack
                         && (r_tcnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (sin_valid) w_next = S_RX_ADDR;
            S_RX_ADDR:  if (sin_valid && w_addr_last) w_next = r_rw ? S_RX_DATA : S_ISSUE;
            S_RX_DATA:  if (sin_valid && w_byte_last) w_next = S_ISSUE;
            S_ISSUE:    if (mem_ready) w_next = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (mem_ack)        w_next = r_rw ? S_IDLE : S_TX;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_TX:       if (w_byte_last) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_addr_vld  <= 1'b0;
            r_wdata_vld <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_done      <= 1'b0;
            r_err       <= w_timeout;
            r_addr_vld  <= 1'b0;
            r_wdata_vld <= 1'b0;
            case (r_state)
                S_IDLE: if (sin_valid) begin
                    r_rw      <= sin;
                    r_bit_cnt <= '0;
                    r_addr    <= '0;
                end
                // fields arrive LSB first: shift in at the top, down towards bit 0
                S_RX_ADDR: if (sin_valid) begin
                    r_addr    <= (r_addr >> 1) | (ADDR_BITS'(sin) << (ADDR_BITS - 1));
                    r_bit_cnt <= w_addr_last ? 5'd0 : r_bit_cnt + 5'd1;
                end
                S_RX_DATA: if (sin_valid) begin
                    r_wdata   <= {sin, r_wdata[7:1]};
                    r_bit_cnt <= w_byte_last ? 5'd0 : r_bit_cnt + 5'd1;
                end
                S_ISSUE: if (mem_ready) begin
                    r_addr_vld  <= 1'b1;
                    r_wdata_vld <= r_rw;
                    r_mem_rw    <= r_rw;
                    r_mem_addr  <= 16'(r_addr);
                    if (r_rw) r_mem_wdata <= r_wdata;
                end
                S_WAIT_ACK: if (mem_ack) begin
                    if (r_rw) r_done <= 1'b1;
                    else begin
                        r_rdata   <= mem_rdata_valid ? mem_rdata : 8'h00;
                        r_bit_cnt <= '0;
                    end
                end
                S_TX: begin
                    r_rdata   <= r_rdata >> 1;
                    r_bit_cnt <= w_byte_last ? 5'd0 : r_bit_cnt + 5'd1;
                    if (w_byte_last) r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_tcnt <= '0;
        else if (r_state != S_WAIT_ACK) r_tcnt <= '0;
        else if (!mem_ack)             r_tcnt <= r_tcnt + 16'd1;
    end

    assign sout            = (r_state == S_TX) & r_rdata[0];
    assign sout_valid      = (r_state == S_TX);
    assign busy            = (r_state != S_IDLE);
    assign done            = r_done;
    assign err             = r_err;
    assign mem_addr        = r_mem_addr;
    assign mem_addr_valid  = r_addr_vld;
    assign mem_wdata       = r_mem_wdata;
    assign mem_wdata_valid = r_wdata_vld;
    assign mem_rw          = r_mem_rw;

endmodule

// File: doc/target_port.md
# target_port

Serial-to-parallel front end for one bus target. Deserializes bit-serial request frames from the serial bus into single-cycle address/data strobes for the downstream 16x8 target memory. It waits for that memory's acknowledge and, for reads, serializes the returned byte back onto the bus. It sits directly upstream of the target memory and drives its target_addr_in / target_data_in / target_rw inputs.

## Interface
- ADDR_BITS, 16, address bits carried per frame (1..16); zero-extended to 16 on mem_addr.
- TIMEOUT, 15, WAIT_ACK cycle limit; used only with TARGET_PORT_TIMEOUT_EN.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sin  in  1  serial request bit, LSB first.
- sin_valid  in  1  sin is sampled only in cycles where this is 1.
- sout  out  1  serial read-data bit, LSB first.
- sout_valid  out  1  sout carries a valid bit.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a transaction completes.
- err  out  1  one-cycle pulse on ack timeout.
- mem_addr  out  16  request address.
- mem_addr_valid  out  1  one-cycle address strobe.
- mem_wdata  out  8  write data.
- mem_wdata_valid  out  1  one-cycle write-data strobe (writes only).
- mem_rw  out  1  1 = write, 0 = read.
- mem_rdata  in  8  read data from memory.
- mem_rdata_valid  in  1  mem_rdata is valid.
- mem_ack  in  1  memory completion acknowledge.
- mem_ready  in  1  memory can accept a strobe.

## Operation
- Frame format: rw bit, then ADDR_BITS address bits, then 8 data bits (writes only). All fields LSB first. Only sin_valid=1 cycles count. Gaps do not abort a frame.
- IDLE: a valid bit is latched as rw; bit_cnt clears; state goes to RX_ADDR.
- RX_ADDR: each valid bit goes to addr[bit_cnt]. After ADDR_BITS bits, state goes to RX_DATA if rw=1, else ISSUE.
- RX_DATA: 8 valid bits go to wdata; state then goes to ISSUE.
- ISSUE: waits indefinitely for mem_ready=1. Then registers a single-cycle strobe: mem_addr_valid=1, mem_rw=rw, and mem_wdata_valid=rw. State goes to WAIT_ACK.
- WAIT_ACK, on mem_ack=1:
  - write: state goes to IDLE and done pulses.
  - read: mem_rdata is captured if mem_rdata_valid=1, otherwise 0x00 is captured; state goes to TX.
- TX: drives sout_valid=1 for 8 consecutive cycles, sout = rdata[0..7]. Then state goes to IDLE and done pulses.
- sin_valid in ISSUE, WAIT_ACK and TX is ignored (bits dropped).
- mem_ack and mem_rdata_valid outside WAIT_ACK are ignored.
- mem_addr and mem_wdata hold their last value between strobes.
- Reset, including mid-frame or mid-TX:
  - all outputs go to 0 and state goes to IDLE;
  - addr, wdata, rdata, bit_cnt and the timeout counter clear;
  - a partial frame is discarded.

## Timing
- Reference point: the last frame bit is sampled at the end of cycle N.
  - Cycle N+1: ISSUE.
  - Cycle N+2: strobe visible, provided mem_ready=1 in N+1. Each cycle of mem_ready=0 delays this by one.
  - Cycle N+3: ack expected (memory has 1-cycle latency).
- Write: done=1 in N+4; state is IDLE in N+4.
- Read: sout_valid=1 in N+4..N+11; done=1 in N+12; state is IDLE in N+12.
- In the done cycle, a new frame's rw bit is accepted.
- Strobes are always exactly one cycle wide. busy is 1 from the cycle after the rw bit until the done/err cycle.

## Configuration
- TARGET_PORT_TIMEOUT_EN defined:
  - WAIT_ACK counts cycles without mem_ack.
  - When the count reaches TIMEOUT, state returns to IDLE, err pulses one cycle, and done is not asserted.
  - Ack arriving in the same cycle as expiry wins (normal completion).
- TARGET_PORT_TIMEOUT_EN undefined: WAIT_ACK waits forever and err is tied 0.
- Timeout never applies in ISSUE.

## Test plan
- Write: rw=1, addr 0x0005, data 0xA5, continuous sin_valid, ready=1 → one strobe with mem_addr=0x0005, mem_wdata=0xA5, mem_rw=1; done exactly 4 cycles after the last bit.
- Read: memory returns 0x3C → sout_valid for 8 cycles with sout=0,0,1,1,1,1,0,0; done the next cycle.
- Gaps: sin_valid toggled 1/0 through a write frame → same strobe values as the continuous case.
- Ready stall: mem_ready=0 for 5 cycles in ISSUE → strobe delayed 5 cycles; busy stays 1; no err even with the macro defined.
- Timeout (macro on, TIMEOUT=15): mem_ack never asserted → err pulse 15 cycles after the strobe, no done, state IDLE.
- Reset mid-TX at bit 3 → sout_valid=0 immediately and busy=0. A subsequent write frame completes normally.
